ps2_host_tx: RTL and testbench
==============================

Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter. It is the outbound counterpart of the keyboard receiver: it sends command bytes to the keyboard, e.g. 0xFF reset, 0xED set-LEDs, 0xF4 enable.
- It drives the shared PS2_clk/PS2_data lines as open-drain pull-down enables. The top level builds the tristates.
- While a frame is in flight it asserts rx_inhibit, so the receiver ignores the host's own traffic.

Parameters:
- INHIBIT_CYCLES, 12000, cycles clk is held low to request-to-send (120 us at 100 MHz).
- SETUP_CYCLES, 200, cycles data and clk are both held low before clk is released.
- TIMEOUT_CYCLES, 2000000, maximum cycles between device clock falling edges, or waiting for bus idle (20 ms).
- FILTER_LEN, 8, consecutive equal synchronized samples needed to accept a level change on ps2_clk_i or ps2_data_i.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- tx_valid  in  1  request to send tx_data.
- tx_data  in  8  byte to send.
- tx_ready  out  1  idle, able to accept a byte.
- tx_done  out  1  one-cycle pulse: frame sent and acknowledged.
- tx_err  out  1  one-cycle pulse: frame aborted.
- err_code  out  2  0 none, 1 NOACK, 2 TIMEOUT; held until the next accepted byte.
- rx_inhibit  out  1  high whenever the block is not in IDLE.
- ps2_clk_i  in  1  raw PS2_clk line.
- ps2_data_i  in  1  raw PS2_data line.
- ps2_clk_oe  out  1  1 pulls PS2_clk low.
- ps2_data_oe  out  1  1 pulls PS2_data low.

Behaviour:
- Reset (asynchronous): ps2_clk_oe=0, ps2_data_oe=0, tx_ready=1, tx_done=0, tx_err=0, err_code=0, rx_inhibit=0, state IDLE. Reset mid-frame releases both lines at once.
- Input conditioning: 2-FF synchronizer, then the filter. Filtered level changes only after FILTER_LEN identical samples. fall = filtered ps2_clk 1->0, a one-cycle strobe. Filtered levels reset to 1.
- Handshake: a byte is accepted when tx_valid & tx_ready in IDLE.
  - On accept: latch the frame shift register {stop=1, parity=~^tx_data, tx_data[7:0]}, clear bit_cnt, clear err_code, go to INHIBIT.
  - tx_ready falls the next cycle. tx_valid while busy is ignored.
- States:
  - IDLE: both oe=0, tx_ready=1.
  - INHIBIT: clk_oe=1, data_oe=0 for exactly INHIBIT_CYCLES cycles, then go to RTS.
  - RTS: clk_oe=1, data_oe=1 (start bit) for SETUP_CYCLES cycles, then go to SEND with clk_oe=0.
  - SEND: data_oe keeps the start bit (1). On fall n (n=1..9), data_oe = ~frame bit n-1 (d0..d7, parity), shifting LSB first. On fall 10, data_oe=0 (stop bit, released), then go to ACK.
  - ACK: on the next fall (11th), sample filtered data. 0 means go to WAIT_IDLE; 1 means error NOACK.
  - WAIT_IDLE: wait until filtered clk=1 and data=1. Then pulse tx_done and go to IDLE.
- Timeout: one counter, cleared on state entry and on every fall in SEND/ACK/WAIT_IDLE. Reaching TIMEOUT_CYCLES means error TIMEOUT.
- Error path: release both lines that cycle, set err_code, pulse tx_err for one cycle, go to IDLE. tx_done is not pulsed.
- Latency: tx_ready is low from acceptance until the cycle after tx_done/tx_err.
- Line discipline: clk_oe and data_oe are never both 1 outside RTS.
- fall during INHIBIT/RTS (device misbehaving) is ignored.

Decomposition:
- Shared package: state enum (IDLE, INHIBIT, RTS, SEND, ACK, WAIT_IDLE), err_code constants (ERR_NONE, ERR_NOACK, ERR_TIMEOUT), frame length 11.
- Sub-module ps2_line_filter (synchronizer + glitch filter + fall strobe), instantiated once per line. The keyboard receiver can reuse it.

Test Plan:
Bench parameters: INHIBIT=20, SETUP=4, TIMEOUT=500, FILTER_LEN=4. Device model has a 40-cycle clock period and acks on clock 11.
- Send 0xED: clk_oe low exactly 20 cycles, then 4 cycles both low. Device samples data 0,1,0,1,1,0,1,1,1,1(par),1(stop). tx_done pulses once, err_code=0.
- Send 0xF4: sampled bits 0,0,0,1,0,1,1,1,1,0(par),1. The device model reports a parity check pass.
- Device never clocks after RTS: tx_err pulses 500 cycles after clk release, err_code=2, both oe=0, tx_ready=1.
- Device leaves data high on clock 11: tx_err with err_code=1, no tx_done.
- Assert rst during the 5th data bit: both oe drop asynchronously, tx_ready=1. The next byte 0xFF then completes normally.
- 2-cycle glitches on ps2_clk_i mid-frame: no extra bits shifted, frame still 0xED correct. tx_valid held high during the frame: exactly one byte accepted per frame.

Source files
------------

// File: rtl/ps2_host_tx_pkg.sv
// Shared types and constants for the PS/2 host-to-device transmitter.
// Also used by anything that needs to decode the debug state or error codes.
package ps2_host_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_RTS,
    ST_SEND,
    ST_ACK,
    ST_WAIT_IDLE
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_NOACK   = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  localparam int FRAME_LEN = 11;
  // The start bit is driven from the RTS->SEND transition, so only
  // data, parity and stop live in the shift register.
  localparam int SHIFT_LEN = FRAME_LEN - 1;

  function automatic logic [SHIFT_LEN-1:0] build_frame(input logic [7:0] d);
    return {1'b1, ~^d, d};
  endfunction

endpackage

// File: rtl/ps2_host_tx_line_filter.sv
// Synchronizer, glitch filter and falling-edge strobe for one raw PS/2 line.
// The filtered level only moves after FILTER_LEN consecutive differing samples.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic fall
);

  localparam int CW = $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync  <= 2'b11;
      cnt   <= '0;
      level <= 1'b1;
      fall  <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      fall <= 1'b0;
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt   <= '0;
        level <= sync[1];
        fall  <= level;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: request-to-send, clocked-out frame, ACK check.
// Drives open-drain pull-down enables; the tristates are built one level up.
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 12000,
  parameter int SETUP_CYCLES   = 200,
  parameter int TIMEOUT_CYCLES = 2000000,
  parameter int FILTER_LEN     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_err,
  output logic [1:0] err_code,
  output logic       rx_inhibit,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output state_t     fsm_state
);

  localparam logic [31:0] INH_LAST   = 32'(INHIBIT_CYCLES - 1);
  localparam logic [31:0] SETUP_LAST = 32'(SETUP_CYCLES - 1);
  localparam logic [31:0] TO_LIMIT   = 32'(TIMEOUT_CYCLES);

  state_t               state, state_n;
  logic [SHIFT_LEN-1:0] shift_q, shift_n;
  logic [3:0]           bit_cnt, bit_cnt_n;
  logic [31:0]          timer, timer_n;
  logic                 data_q, data_n;
  logic [1:0]           err_q, err_n;
  logic                 clk_f, clk_fall, data_f, data_fall_unused;
  logic                 timed, timeout_hit;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk   (clk),
    .rst   (rst),
    .raw   (ps2_clk_i),
    .level (clk_f),
    .fall  (clk_fall)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
    .clk   (clk),
    .rst   (rst),
    .raw   (ps2_data_i),
    .level (data_f),
    .fall  (data_fall_unused)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      shift_q <= '0;
      bit_cnt <= '0;
      timer   <= '0;
      data_q  <= 1'b0;
      err_q   <= ERR_NONE;
    end else begin
      state   <= state_n;
      shift_q <= shift_n;
      bit_cnt <= bit_cnt_n;
      timer   <= timer_n;
      data_q  <= data_n;
      err_q   <= err_n;
    end
  end

  // Handshake: a byte transfers on a cycle with tx_valid & tx_ready; tx_ready
  // is high only in IDLE, so tx_valid while busy is simply not looked at.
  always_comb begin
    state_n     = state;
    shift_n     = shift_q;
    bit_cnt_n   = bit_cnt;
    data_n      = data_q;
    err_n       = err_q;
    tx_done     = 1'b0;
    tx_err      = 1'b0;
    timed       = (state == ST_SEND) || (state == ST_ACK) || (state == ST_WAIT_IDLE);
    timeout_hit = timed && (timer == TO_LIMIT);

    case (state)
      ST_IDLE: begin
        if (tx_valid) begin
          shift_n   = build_frame(tx_data);
          bit_cnt_n = '0;
          err_n     = ERR_NONE;
          state_n   = ST_INHIBIT;
        end
      end
      ST_INHIBIT: begin
        if (timer == INH_LAST) state_n = ST_RTS;
      end
      ST_RTS: begin
        if (timer == SETUP_LAST) begin
          data_n  = 1'b1;
          state_n = ST_SEND;
        end
      end
      ST_SEND: begin
        // Tenth fall shifts out the stop bit (1), which releases the line.
        if (clk_fall) begin
          data_n    = ~shift_q[0];
          shift_n   = shift_q >> 1;
          bit_cnt_n = bit_cnt + 4'd1;
          if (bit_cnt == 4'd9) state_n = ST_ACK;
        end
      end
      ST_ACK: begin
        if (clk_fall) begin
          if (data_f) begin
            err_n   = ERR_NOACK;
            tx_err  = 1'b1;
            state_n = ST_IDLE;
          end else begin
            state_n = ST_WAIT_IDLE;
          end
        end
      end
      ST_WAIT_IDLE: begin
        if (clk_f && data_f) begin
          tx_done = 1'b1;
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase

    if (timeout_hit) begin
      err_n   = ERR_TIMEOUT;
      tx_err  = 1'b1;
      tx_done = 1'b0;
      state_n = ST_IDLE;
    end

    if (state_n != state || state == ST_IDLE) begin
      timer_n = '0;
    end else if (timed && clk_fall) begin
      timer_n = '0;
    end else begin
      timer_n = timer + 32'd1;
    end
  end

  assign ps2_clk_oe  = (state == ST_INHIBIT) || (state == ST_RTS);
  assign ps2_data_oe = (state == ST_RTS) || ((state == ST_SEND) && data_q && !timeout_hit);
  assign tx_ready    = (state == ST_IDLE);
  assign rx_inhibit  = (state != ST_IDLE);
  assign err_code    = err_q;
  assign fsm_state   = state;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a behavioural PS/2 device and a frame scoreboard.
module tb_ps2_host_tx;
  import ps2_host_tx_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready, tx_done, tx_err, rx_inhibit;
  logic [1:0] err_code;
  logic       ps2_clk_i, ps2_data_i, ps2_clk_oe, ps2_data_oe;
  state_t     fsm_state;

  logic dev_clk_low = 1'b0;
  logic dev_data_low = 1'b0;
  logic clk_glitch = 1'b0;

  // Open-drain bus: either side may pull low; the glitch term flips the clock.
  assign ps2_clk_i  = ~(ps2_clk_oe | dev_clk_low) ^ clk_glitch;
  assign ps2_data_i = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES (20),
    .SETUP_CYCLES   (4),
    .TIMEOUT_CYCLES (500),
    .FILTER_LEN     (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_ready    (tx_ready),
    .tx_done     (tx_done),
    .tx_err      (tx_err),
    .err_code    (err_code),
    .rx_inhibit  (rx_inhibit),
    .ps2_clk_i   (ps2_clk_i),
    .ps2_data_i  (ps2_data_i),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .fsm_state   (fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int accept_cnt = 0;
  logic [10:0] exp_q[$];

  always @(posedge clk) begin
    if (!rst && tx_done) done_cnt++;
    if (!rst && tx_err) err_cnt++;
    if (!rst && tx_valid && tx_ready) accept_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // driver: present a byte, wait for acceptance, push the expected wire frame
  task automatic send_byte(input logic [7:0] d, input bit hold);
    int n;
    n = 0;
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = d;
    while (!tx_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    exp_q.push_back({1'b1, ~^d, d, 1'b0});
    @(negedge clk);
    if (!hold) tx_valid = 1'b0;
    check("ready_low_after_accept", {31'd0, tx_ready}, 32'd0);
    check("inhibit_rx_busy", {31'd0, rx_inhibit}, 32'd1);
  endtask

  // device side: measure the host's request-to-send phases
  task automatic host_request(output int inh, output int setup);
    int n;
    n = 0;
    inh = 0;
    setup = 0;
    while (!ps2_clk_oe && n < 100) begin
      @(negedge clk);
      n++;
    end
    while (ps2_clk_oe && !ps2_data_oe && inh < 1000) begin
      inh++;
      @(negedge clk);
    end
    while (ps2_clk_oe && ps2_data_oe && setup < 1000) begin
      setup++;
      @(negedge clk);
    end
  endtask

  task automatic half_phase(input bit glitch);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (glitch && k == 8) clk_glitch = 1'b1;
      if (glitch && k == 10) clk_glitch = 1'b0;
    end
  endtask

  // device side: clock 11 bits, sampling data at the end of each high phase
  task automatic dev_clock_frame(input bit ack, input bit glitch, input int abort_fall,
                                 output logic [10:0] bits);
    bits = '0;
    half_phase(glitch);
    bits[0] = ps2_data_i;
    for (int i = 1; i <= 10; i++) begin
      dev_clk_low = 1'b1;
      half_phase(glitch);
      if (abort_fall == i) return;
      dev_clk_low = 1'b0;
      half_phase(glitch);
      bits[i] = ps2_data_i;
    end
    dev_data_low = ack;
    repeat (5) @(negedge clk);
    dev_clk_low = 1'b1;
    half_phase(1'b0);
    dev_clk_low = 1'b0;
    repeat (10) @(negedge clk);
    dev_data_low = 1'b0;
  endtask

  task automatic wait_end();
    int n;
    n = 0;
    while (!tx_done && !tx_err && n < 300) begin
      @(negedge clk);
      n++;
    end
    tx_valid = 1'b0;
    @(negedge clk);
  endtask

  // one complete acknowledged frame with scoreboard comparison
  task automatic good_frame(input logic [7:0] d, input bit glitch);
    int inh, setup, d0, e0, a0;
    logic [10:0] bits, exp;
    d0 = done_cnt;
    e0 = err_cnt;
    a0 = accept_cnt;
    send_byte(d, glitch);
    host_request(inh, setup);
    check("inhibit_cycles", inh, 20);
    check("setup_cycles", setup, 4);
    dev_clock_frame(1'b1, glitch, 0, bits);
    exp = exp_q.pop_front();
    check("frame_bits", {21'd0, bits}, {21'd0, exp});
    check("device_parity_ok", {31'd0, ^bits[9:1]}, 32'd1);
    wait_end();
    check("done_pulses", done_cnt - d0, 1);
    check("no_err_pulse", err_cnt - e0, 0);
    check("accepts_per_frame", accept_cnt - a0, 1);
    check("err_code_none", {30'd0, err_code}, {30'd0, ERR_NONE});
    check("ready_after_done", {31'd0, tx_ready}, 32'd1);
  endtask

  initial begin
    int inh, setup, n, e0, d0;
    logic [10:0] bits, exp;

    repeat (3) @(negedge clk);
    check("rst_ready", {31'd0, tx_ready}, 32'd1);
    check("rst_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
    check("rst_data_oe", {31'd0, ps2_data_oe}, 32'd0);
    check("rst_err_code", {30'd0, err_code}, 32'd0);
    check("rst_rx_inhibit", {31'd0, rx_inhibit}, 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_done", {31'd0, tx_done}, 32'd0);
    check("idle_err", {31'd0, tx_err}, 32'd0);
    check("idle_state", {29'd0, fsm_state}, {29'd0, ST_IDLE});

    good_frame(8'hED, 1'b0);
    good_frame(8'hF4, 1'b0);

    // device never clocks: timeout counted from clock release
    e0 = err_cnt;
    send_byte(8'h55, 1'b0);
    host_request(inh, setup);
    check("to_clk_released", {31'd0, ps2_clk_oe}, 32'd0);
    n = 0;
    while (!tx_err && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("timeout_latency", n, 500);
    check("to_data_oe_released", {31'd0, ps2_data_oe}, 32'd0);
    @(negedge clk);
    check("to_err_code", {30'd0, err_code}, {30'd0, ERR_TIMEOUT});
    check("to_err_pulse", err_cnt - e0, 1);
    check("to_ready", {31'd0, tx_ready}, 32'd1);
    check("to_clk_oe_idle", {31'd0, ps2_clk_oe}, 32'd0);
    void'(exp_q.pop_front());

    // device leaves data high on the 11th clock
    e0 = err_cnt;
    d0 = done_cnt;
    send_byte(8'h0F, 1'b0);
    host_request(inh, setup);
    dev_clock_frame(1'b0, 1'b0, 0, bits);
    exp = exp_q.pop_front();
    check("noack_frame_bits", {21'd0, bits}, {21'd0, exp});
    repeat (5) @(negedge clk);
    check("noack_err_pulse", err_cnt - e0, 1);
    check("noack_no_done", done_cnt - d0, 0);
    check("noack_err_code", {30'd0, err_code}, {30'd0, ERR_NOACK});

    // reset while the fifth data bit is on the wire
    send_byte(8'hEF, 1'b0);
    host_request(inh, setup);
    dev_clock_frame(1'b1, 1'b0, 5, bits);
    check("pre_rst_data_oe", {31'd0, ps2_data_oe}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_async_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
    check("rst_async_data_oe", {31'd0, ps2_data_oe}, 32'd0);
    check("rst_async_ready", {31'd0, tx_ready}, 32'd1);
    dev_clk_low = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    void'(exp_q.pop_front());
    repeat (2) @(negedge clk);
    check("post_rst_err_code", {30'd0, err_code}, 32'd0);
    good_frame(8'hFF, 1'b0);

    // clock glitches mid-frame with tx_valid held high throughout
    good_frame(8'hED, 1'b1);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
